l2_store_responder: RTL and testbench

L2-side endpoint for store-queue traffic from one core: accepts store, synchronized-store and flush requests through the dequeue handshake, and performs writes or flushes on the L2 data array port. Tracks per-thread load-link reservations to decide synchronized-store success, then returns one response per request, tagged with the requester's queue index. Sits between the core's L2 interface and the L2 data array write port.

---
 rtl/l2_store_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_l2_store_responder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_store_responder.sv
// l2_store_responder
// L2-side endpoint for one core's store queue. Accepts plain stores,
// synchronized (store-conditional) stores and flushes, drives the L2 data
// array write/flush port, tracks per-thread load-link reservations and
// returns one tagged response per accepted request.
module l2_store_responder #(
    parameter int NUM_THREADS = 4,
    parameter int IDX_W       = $clog2(NUM_THREADS)
) (
    input  logic               clk,
    input  logic               reset,

    // Store-queue dequeue handshake
    input  logic               sq_dequeue_ready,
    input  logic [31:0]        sq_dequeue_addr,
    input  logic [IDX_W-1:0]   sq_dequeue_idx,
    input  logic [63:0]        sq_dequeue_mask,
    input  logic [511:0]       sq_dequeue_data,
    input  logic               sq_dequeue_synchronized,
    input  logic               sq_dequeue_flush,
    output logic               sq_dequeue_ack,

    // Load-link notification
    input  logic               ll_en,
    input  logic [IDX_W-1:0]   ll_thread_idx,
    input  logic [31:0]        ll_addr,

    // L2 data array port
    output logic               mem_write_en,
    output logic               mem_flush_en,
    output logic [31:0]        mem_addr,
    output logic [63:0]        mem_mask,
    output logic [511:0]       mem_data,
    input  logic               mem_ack,

    // Response back to the store queue
    output logic               storebuf_l2_response_valid,
    output logic [IDX_W-1:0]   storebuf_l2_response_idx,
    output logic               storebuf_l2_sync_success
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int LINE_W = 26;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic               write_en_q,  write_en_d;
    logic               flush_en_q,  flush_en_d;
    logic [31:0]        addr_q,      addr_d;
    logic [63:0]        mask_q,      mask_d;
    logic [511:0]       data_q,      data_d;
    logic               sync_ok_q,   sync_ok_d;
    logic               resp_valid_q, resp_valid_d;
    logic [IDX_W-1:0]   resp_idx_q,  resp_idx_d;
    logic               resp_sync_q, resp_sync_d;

    // Reservation table: one valid bit and one line address per thread
    logic [NUM_THREADS-1:0] resv_valid_q, resv_valid_d;
    logic [LINE_W-1:0]      resv_addr_q [NUM_THREADS];
    logic [LINE_W-1:0]      resv_addr_d [NUM_THREADS];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] ll_line;
    logic              accept;
    logic              resv_hit;
    logic              req_is_write;
    logic              req_sync_fail;
    logic              unused_low_bits;

    assign req_line = sq_dequeue_addr[31:6];
    assign ll_line  = ll_addr[31:6];

    // Byte offset within the line carries no meaning at this level.
    assign unused_low_bits = ^{sq_dequeue_addr[5:0], ll_addr[5:0]};

    // Acceptance only while idle and out of reset; combinational so the
    // store queue can dequeue in the same cycle.
    assign sq_dequeue_ack = sq_dequeue_ready && (state_q == IDLE) && !reset;
    assign accept         = sq_dequeue_ack;

    // Reservation lookup sees the table as it stood before this cycle.
    assign resv_hit      = resv_valid_q[sq_dequeue_idx] &&
                           (resv_addr_q[sq_dequeue_idx] == req_line);
    assign req_is_write  = !sq_dequeue_flush &&
                           (!sq_dequeue_synchronized || resv_hit);
    assign req_sync_fail = !sq_dequeue_flush && sq_dequeue_synchronized &&
                           !resv_hit;

    // Next reservation table: accept-driven clears first, then load-link
    // sets so a same-cycle load-link always wins for its own thread.
    always_comb begin
        resv_valid_d = resv_valid_q;
        for (int t = 0; t < NUM_THREADS; t++) begin
            resv_addr_d[t] = resv_addr_q[t];
        end

        if (accept) begin
            if (req_is_write) begin
                for (int t = 0; t < NUM_THREADS; t++) begin
                    if (resv_addr_q[t] == req_line) begin
                        resv_valid_d[t] = 1'b0;
                    end
                end
            end
            if (req_sync_fail) begin
                resv_valid_d[sq_dequeue_idx] = 1'b0;
            end
        end

        if (ll_en) begin
            resv_valid_d[ll_thread_idx] = 1'b1;
            resv_addr_d[ll_thread_idx]  = ll_line;
        end
    end

    // Next FSM state and the values of every registered output.
    always_comb begin
        state_d      = state_q;
        write_en_d   = write_en_q;
        flush_en_d   = flush_en_q;
        addr_d       = addr_q;
        mask_d       = mask_q;
        data_d       = data_q;
        sync_ok_d    = sync_ok_q;
        resp_idx_d   = resp_idx_q;
        resp_valid_d = 1'b0;
        resp_sync_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = {req_line, 6'b0};
                    mask_d     = sq_dequeue_mask;
                    data_d     = sq_dequeue_data;
                    resp_idx_d = sq_dequeue_idx;
                    sync_ok_d  = sq_dequeue_synchronized && !sq_dequeue_flush &&
                                 resv_hit;
                    if (req_is_write || sq_dequeue_flush) begin
                        state_d    = ISSUE;
                        write_en_d = req_is_write;
                        flush_en_d = sq_dequeue_flush;
                    end else begin
                        // Failed store-conditional: skip the array entirely.
                        state_d      = RESPOND;
                        resp_valid_d = 1'b1;
                        resp_sync_d  = 1'b0;
                    end
                end
            end

            ISSUE: begin
                // Request held stable until the array takes it.
                if (mem_ack) begin
                    state_d      = RESPOND;
                    write_en_d   = 1'b0;
                    flush_en_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_sync_d  = sync_ok_q;
                end
            end

            RESPOND: begin
                state_d = IDLE;
            end

            default: begin
                state_d    = IDLE;
                write_en_d = 1'b0;
                flush_en_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers; reset abandons any request in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_en_q   <= 1'b0;
            flush_en_q   <= 1'b0;
            addr_q       <= '0;
            mask_q       <= '0;
            data_q       <= '0;
            sync_ok_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_idx_q   <= '0;
            resp_sync_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_en_q   <= write_en_d;
            flush_en_q   <= flush_en_d;
            addr_q       <= addr_d;
            mask_q       <= mask_d;
            data_q       <= data_d;
            sync_ok_q    <= sync_ok_d;
            resp_valid_q <= resp_valid_d;
            resp_idx_q   <= resp_idx_d;
            resp_sync_q  <= resp_sync_d;
        end
    end

    // Reservation valid bits; reset invalidates every reservation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resv_valid_q <= '0;
        end else begin
            resv_valid_q <= resv_valid_d;
        end
    end

    // Reservation addresses are meaningless while invalid, so no reset.
    always_ff @(posedge clk) begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            resv_addr_q[t] <= resv_addr_d[t];
        end
    end

    assign mem_write_en               = write_en_q;
    assign mem_flush_en               = flush_en_q;
    assign mem_addr                   = addr_q;
    assign mem_mask                   = mask_q;
    assign mem_data                   = data_q;
    assign storebuf_l2_response_valid = resp_valid_q;
    assign storebuf_l2_response_idx   = resp_idx_q;
    assign storebuf_l2_sync_success   = resp_sync_q;

endmodule

// File: tb/tb_l2_store_responder.sv
// tb_l2_store_responder
// Directed scenarios plus a randomized back-to-back run, all checked
// against a request-level reference model of the reservation table.
module tb_l2_store_responder;

    localparam int NT = 4;
    localparam int IW = 2;

    logic           clk;
    logic           reset;
    logic           sq_dequeue_ready;
    logic [31:0]    sq_dequeue_addr;
    logic [IW-1:0]  sq_dequeue_idx;
    logic [63:0]    sq_dequeue_mask;
    logic [511:0]   sq_dequeue_data;
    logic           sq_dequeue_synchronized;
    logic           sq_dequeue_flush;
    logic           sq_dequeue_ack;
    logic           ll_en;
    logic [IW-1:0]  ll_thread_idx;
    logic [31:0]    ll_addr;
    logic           mem_write_en;
    logic           mem_flush_en;
    logic [31:0]    mem_addr;
    logic [63:0]    mem_mask;
    logic [511:0]   mem_data;
    logic           mem_ack;
    logic           storebuf_l2_response_valid;
    logic [IW-1:0]  storebuf_l2_response_idx;
    logic           storebuf_l2_sync_success;

    int n_checks;
    int n_fail;

    // Reference reservation table
    bit          resv_v [NT];
    logic [25:0] resv_a [NT];

    l2_store_responder #(.NUM_THREADS(NT)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .sq_dequeue_ready           (sq_dequeue_ready),
        .sq_dequeue_addr            (sq_dequeue_addr),
        .sq_dequeue_idx             (sq_dequeue_idx),
        .sq_dequeue_mask            (sq_dequeue_mask),
        .sq_dequeue_data            (sq_dequeue_data),
        .sq_dequeue_synchronized    (sq_dequeue_synchronized),
        .sq_dequeue_flush           (sq_dequeue_flush),
        .sq_dequeue_ack             (sq_dequeue_ack),
        .ll_en                      (ll_en),
        .ll_thread_idx              (ll_thread_idx),
        .ll_addr                    (ll_addr),
        .mem_write_en               (mem_write_en),
        .mem_flush_en               (mem_flush_en),
        .mem_addr                   (mem_addr),
        .mem_mask                   (mem_mask),
        .mem_data                   (mem_data),
        .mem_ack                    (mem_ack),
        .storebuf_l2_response_valid (storebuf_l2_response_valid),
        .storebuf_l2_response_idx   (storebuf_l2_response_idx),
        .storebuf_l2_sync_success   (storebuf_l2_sync_success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time bound on the whole run.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "timeout");
    end

    function automatic logic [511:0] rand_data();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Request-level semantics: success needs a live matching reservation;
    // a performed write kills every reservation on the line; a failed
    // store-conditional kills the requester's own reservation.
    task automatic model_accept(input logic [31:0] a, input int idx, input bit s,
                                input bit f, output bit succ, output bit mem,
                                output bit wr);
        bit hit;
        hit  = resv_v[idx] && (resv_a[idx] == a[31:6]);
        succ = s && !f && hit;
        wr   = !f && (!s || hit);
        mem  = f || wr;
        if (wr) begin
            for (int t = 0; t < NT; t++)
                if (resv_v[t] && resv_a[t] == a[31:6]) resv_v[t] = 1'b0;
        end
        if (!f && s && !hit) resv_v[idx] = 1'b0;
    endtask

    task automatic model_ll(input int t, input logic [31:0] a);
        resv_v[t] = 1'b1;
        resv_a[t] = a[31:6];
    endtask

    task automatic do_ll(input int t, input logic [31:0] a);
        ll_en = 1'b1; ll_thread_idx = t[IW-1:0]; ll_addr = a;
        @(posedge clk); #1;
        ll_en = 1'b0;
        model_ll(t, a);
    endtask

    // One request from an idle DUT; entered and left #1 after a posedge.
    task automatic issue_req(input logic [31:0] a, input int idx, input logic [63:0] m,
                             input logic [511:0] d, input bit s, input bit f,
                             input int dly, input bit keep_ready, input string nm);
        bit succ, mem, wr;
        sq_dequeue_ready = 1'b1; sq_dequeue_addr = a; sq_dequeue_idx = idx[IW-1:0];
        sq_dequeue_mask = m; sq_dequeue_data = d;
        sq_dequeue_synchronized = s; sq_dequeue_flush = f;
        @(negedge clk);
        n_checks++;
        if (sq_dequeue_ack !== 1'b1) begin
            n_fail++; $display("FAIL %s_ack: got %b required 1", nm, sq_dequeue_ack);
        end
        model_accept(a, idx, s, f, succ, mem, wr);
        @(posedge clk); #1;
        if (!keep_ready) sq_dequeue_ready = 1'b0;
        if (mem) begin
            for (int c = 0; c <= dly; c++) begin
                if (c == dly) mem_ack = 1'b1;
                @(negedge clk);
                n_checks++;
                if ({mem_write_en, mem_flush_en} !== {wr, f}) begin
                    n_fail++; $display("FAIL %s_mem_en: got wr=%b fl=%b required wr=%b fl=%b",
                                       nm, mem_write_en, mem_flush_en, wr, f);
                end
                n_checks++;
                if (mem_addr !== {a[31:6], 6'b0}) begin
                    n_fail++; $display("FAIL %s_mem_addr: got %h required %h", nm, mem_addr, {a[31:6], 6'b0});
                end
                if (wr) begin
                    n_checks++;
                    if (mem_mask !== m || mem_data !== d) begin
                        n_fail++; $display("FAIL %s_mem_payload: got mask %h required %h (data match=%b)",
                                           nm, mem_mask, m, mem_data === d);
                    end
                end
                n_checks++;
                if (storebuf_l2_response_valid !== 1'b0 || sq_dequeue_ack !== 1'b0) begin
                    n_fail++; $display("FAIL %s_issue_quiet: got resp=%b ack=%b required 0 0",
                                       nm, storebuf_l2_response_valid, sq_dequeue_ack);
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        @(negedge clk);
        n_checks++;
        if (storebuf_l2_response_valid !== 1'b1 || storebuf_l2_response_idx !== idx[IW-1:0] ||
            storebuf_l2_sync_success !== succ) begin
            n_fail++; $display("FAIL %s_resp: got v=%b idx=%0d ss=%b required v=1 idx=%0d ss=%b", nm,
                               storebuf_l2_response_valid, storebuf_l2_response_idx,
                               storebuf_l2_sync_success, idx, succ);
        end
        n_checks++;
        if (mem_write_en !== 1'b0 || mem_flush_en !== 1'b0 || sq_dequeue_ack !== 1'b0) begin
            n_fail++; $display("FAIL %s_resp_quiet: got wr=%b fl=%b ack=%b required 0 0 0",
                               nm, mem_write_en, mem_flush_en, sq_dequeue_ack);
        end
        @(posedge clk); #1;
        sq_dequeue_ready = 1'b0;
        n_checks++;
        if (storebuf_l2_response_valid !== 1'b0 || storebuf_l2_sync_success !== 1'b0) begin
            n_fail++; $display("FAIL %s_resp_once: got v=%b ss=%b required 0 0", nm,
                               storebuf_l2_response_valid, storebuf_l2_sync_success);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sq_dequeue_ready = 1'b1; sq_dequeue_addr = 32'h1000; mem_ack = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({sq_dequeue_ack, mem_write_en, mem_flush_en, storebuf_l2_response_valid,
             storebuf_l2_sync_success} !== 5'b0 || mem_addr !== 32'h0 || mem_mask !== 64'h0 ||
            mem_data !== 512'h0 || storebuf_l2_response_idx !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got ack=%b wr=%b fl=%b v=%b addr=%h required all 0",
                               sq_dequeue_ack, mem_write_en, mem_flush_en,
                               storebuf_l2_response_valid, mem_addr);
        end
        @(posedge clk); #1;
        sq_dequeue_ready = 1'b0; mem_ack = 1'b0; reset = 1'b0;
        for (int t = 0; t < NT; t++) resv_v[t] = 1'b0;
    endtask

    task automatic test_plain_store();
        issue_req(32'h1000, 2, 64'hF, rand_data(), 1'b0, 1'b0, 0, 1'b0, "plain");
        issue_req(32'h1234_5678, 1, {$urandom, $urandom}, rand_data(), 1'b0, 1'b0, 1, 1'b0, "plain_unaligned");
    endtask

    task automatic test_sync_store();
        do_ll(1, 32'h2040);
        issue_req(32'h2040, 1, 64'hFF00, rand_data(), 1'b1, 1'b0, 0, 1'b0, "sync_ok");
        issue_req(32'h2040, 1, 64'hFF00, rand_data(), 1'b1, 1'b0, 0, 1'b0, "sync_again");
        // Reservation on another line does not help.
        do_ll(0, 32'h2080);
        issue_req(32'h20C0, 0, 64'h1, rand_data(), 1'b1, 1'b0, 0, 1'b0, "sync_wrong_line");
    endtask

    task automatic test_resv_clear();
        do_ll(0, 32'h3000);
        do_ll(3, 32'h3000);
        issue_req(32'h3010, 2, 64'h3, rand_data(), 1'b0, 1'b0, 0, 1'b0, "clear_write");
        issue_req(32'h3000, 0, 64'h3, rand_data(), 1'b1, 1'b0, 0, 1'b0, "clear_sync0");
        issue_req(32'h3000, 3, 64'h3, rand_data(), 1'b1, 1'b0, 0, 1'b0, "clear_sync3");
        // Flush leaves reservations alone.
        do_ll(2, 32'h3400);
        issue_req(32'h3400, 1, 64'h0, rand_data(), 1'b0, 1'b1, 0, 1'b0, "flush_keep");
        issue_req(32'h3400, 2, 64'h5, rand_data(), 1'b1, 1'b0, 0, 1'b0, "sync_after_flush");
    endtask

    task automatic test_ll_same_cycle();
        do_ll(0, 32'h3800);
        ll_en = 1'b1; ll_thread_idx = 2'd0; ll_addr = 32'h3800;
        issue_req(32'h3800, 2, 64'hA, rand_data(), 1'b0, 1'b0, 0, 1'b0, "ll_race_write");
        ll_en = 1'b0;
        model_ll(0, 32'h3800);
        issue_req(32'h3800, 0, 64'hA, rand_data(), 1'b1, 1'b0, 0, 1'b0, "ll_race_sync");
    endtask

    task automatic test_flush_delay();
        issue_req(32'h4000, 0, 64'hFFFF, rand_data(), 1'b0, 1'b1, 2, 1'b1, "flush_delay");
        issue_req(32'h4100, 3, {$urandom, $urandom}, rand_data(), 1'b0, 1'b0, 4, 1'b1, "write_delay");
    endtask

    task automatic test_reset_mid();
        do_ll(1, 32'h6000);
        sq_dequeue_ready = 1'b1; sq_dequeue_addr = 32'h7000; sq_dequeue_idx = 2'd3;
        sq_dequeue_synchronized = 1'b0; sq_dequeue_flush = 1'b0; sq_dequeue_mask = 64'h1;
        @(posedge clk); #1;
        sq_dequeue_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_write_en !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_issue: got wr=%b required 1", mem_write_en);
        end
        #2 reset = 1'b1; sq_dequeue_ready = 1'b1;
        #1;
        n_checks++;
        if (mem_write_en !== 1'b0 || sq_dequeue_ack !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got wr=%b ack=%b required 0 0", mem_write_en, sq_dequeue_ack);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; sq_dequeue_ready = 1'b0; mem_ack = 1'b0;
        for (int t = 0; t < NT; t++) resv_v[t] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (storebuf_l2_response_valid !== 1'b0 || mem_write_en !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_no_resp: got v=%b wr=%b required 0 0",
                                   storebuf_l2_response_valid, mem_write_en);
            end
        end
        @(posedge clk); #1;
        issue_req(32'h6000, 1, 64'h1, rand_data(), 1'b1, 1'b0, 0, 1'b0, "rstmid_sync");
    endtask

    // Continuous ready with random traffic; request lifecycle tracked as
    // phase 0 (idle), 1 (waiting for the array), 2 (response due).
    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        int phase, n_acc, n_resp, p_idx;
        bit p_succ, p_mem, p_wr, p_f;
        logic [31:0] p_addr;
        logic [63:0] p_mask;
        logic [511:0] p_data;
        addrs[0] = 32'h5000; addrs[1] = 32'h5040; addrs[2] = 32'h5080; addrs[3] = 32'h9FC0;
        phase = 0; n_acc = 0; n_resp = 0;
        p_idx = 0; p_succ = 0; p_mem = 0; p_wr = 0; p_f = 0;
        p_addr = '0; p_mask = '0; p_data = '0;
        sq_dequeue_ready = 1'b1;
        for (int cyc = 0; cyc < 420; cyc++) begin
            if (cyc == 400) sq_dequeue_ready = 1'b0;
            sq_dequeue_addr = addrs[$urandom_range(3)] | ($urandom & 32'h3F);
            sq_dequeue_idx  = IW'($urandom_range(NT - 1));
            sq_dequeue_mask = {$urandom, $urandom};
            sq_dequeue_data = rand_data();
            sq_dequeue_synchronized = ($urandom_range(1) == 1);
            sq_dequeue_flush = ($urandom_range(5) == 0);
            ll_en = ($urandom_range(2) == 0);
            ll_thread_idx = IW'($urandom_range(NT - 1));
            ll_addr = addrs[$urandom_range(3)];
            mem_ack = ($urandom_range(1) == 1);
            @(negedge clk);
            n_checks++;
            if (sq_dequeue_ack !== (phase == 0 && sq_dequeue_ready)) begin
                n_fail++; $display("FAIL b2b_ack cyc %0d: got %b required %b", cyc, sq_dequeue_ack,
                                   (phase == 0 && sq_dequeue_ready));
            end
            n_checks++;
            if (mem_write_en !== (phase == 1 && p_wr) || mem_flush_en !== (phase == 1 && p_f)) begin
                n_fail++; $display("FAIL b2b_mem_en cyc %0d: got wr=%b fl=%b required wr=%b fl=%b", cyc,
                                   mem_write_en, mem_flush_en, phase == 1 && p_wr, phase == 1 && p_f);
            end
            if (phase == 1) begin
                n_checks++;
                if (mem_addr !== {p_addr[31:6], 6'b0} || (p_wr && (mem_mask !== p_mask || mem_data !== p_data))) begin
                    n_fail++; $display("FAIL b2b_mem_req cyc %0d: got addr %h mask %h required addr %h mask %h",
                                       cyc, mem_addr, mem_mask, {p_addr[31:6], 6'b0}, p_mask);
                end
            end
            n_checks++;
            if (storebuf_l2_response_valid !== (phase == 2) ||
                (phase == 2 && (storebuf_l2_response_idx !== p_idx[IW-1:0] ||
                                storebuf_l2_sync_success !== p_succ)) ||
                (phase != 2 && storebuf_l2_sync_success !== 1'b0)) begin
                n_fail++; $display("FAIL b2b_resp cyc %0d: got v=%b idx=%0d ss=%b required v=%b idx=%0d ss=%b",
                                   cyc, storebuf_l2_response_valid, storebuf_l2_response_idx,
                                   storebuf_l2_sync_success, phase == 2, p_idx, p_succ && phase == 2);
            end
            case (phase)
                0: if (sq_dequeue_ready) begin
                       p_idx = int'(sq_dequeue_idx); p_addr = sq_dequeue_addr;
                       p_mask = sq_dequeue_mask; p_data = sq_dequeue_data; p_f = sq_dequeue_flush;
                       model_accept(sq_dequeue_addr, p_idx, sq_dequeue_synchronized,
                                    sq_dequeue_flush, p_succ, p_mem, p_wr);
                       n_acc++;
                       phase = p_mem ? 1 : 2;
                   end
                1: if (mem_ack) phase = 2;
                default: begin phase = 0; n_resp++; end
            endcase
            if (ll_en) model_ll(int'(ll_thread_idx), ll_addr);
            @(posedge clk); #1;
        end
        ll_en = 1'b0; mem_ack = 1'b0;
        n_checks++;
        if (phase != 0 || n_acc != n_resp) begin
            n_fail++; $display("FAIL b2b_count: got %0d responses for %0d accepts (phase %0d) required equal, idle",
                               n_resp, n_acc, phase);
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        sq_dequeue_ready = 1'b0; sq_dequeue_addr = '0; sq_dequeue_idx = '0;
        sq_dequeue_mask = '0; sq_dequeue_data = '0;
        sq_dequeue_synchronized = 1'b0; sq_dequeue_flush = 1'b0;
        ll_en = 1'b0; ll_thread_idx = '0; ll_addr = '0; mem_ack = 1'b0;
        for (int t = 0; t < NT; t++) begin resv_v[t] = 1'b0; resv_a[t] = '0; end

        test_reset();
        test_plain_store();
        test_sync_store();
        test_resv_clear();
        test_ll_same_cycle();
        test_flush_delay();
        test_reset_mid();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
